// File: rtl/voice_allocator.sv
// Polyphony controller: assigns MIDI note-on/off events to NUM_VOICES tone generators
// using retrigger, then free voice, then least-recently-assigned theft.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int IDX_W      = $clog2(NUM_VOICES)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ev_valid,
    output logic                      ev_ready,
    input  logic                      ev_on,
    input  logic [6:0]                ev_note,
    input  logic [6:0]                ev_velocity,
    input  logic                      all_off,
    output logic [7*NUM_VOICES-1:0]   voice_note,
    output logic [7*NUM_VOICES-1:0]   voice_volume,
    output logic [NUM_VOICES-1:0]     voice_active,
    output logic [NUM_VOICES-1:0]     voice_restart,
    output logic [1:0]                dbg_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] APPLY = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    // Handshake: an event transfers on the rising edge where ev_valid && ev_ready;
    // ev_ready is high only in IDLE, and the event fields are captured at that edge.
    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_scan_idx;
    logic             r_ev_sound;
    logic [6:0]       r_ev_note;
    logic [6:0]       r_ev_vel;
    logic             r_match_found;
    logic [IDX_W-1:0] r_match_idx;
    logic             r_free_found;
    logic [IDX_W-1:0] r_free_idx;
    logic [IDX_W-1:0] r_oldest_idx;

    logic [6:0]       r_note   [NUM_VOICES];
    logic [6:0]       r_vol    [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_active;
    logic [NUM_VOICES-1:0] r_restart;
    logic [IDX_W-1:0] r_rank   [NUM_VOICES];

    logic             w_accept;
    logic             w_apply_on;
    logic             w_apply_off;
    logic [IDX_W-1:0] w_target;

    // all_off wins over both a new accept and a pending APPLY.
    assign w_accept    = (r_state == IDLE) && ev_valid && !all_off;
    assign w_apply_on  = (r_state == APPLY) && !all_off && r_ev_sound;
    assign w_apply_off = (r_state == APPLY) && !all_off && !r_ev_sound && r_match_found;
    assign w_target    = r_match_found ? r_match_idx :
                         r_free_found  ? r_free_idx  : r_oldest_idx;

    assign ev_ready      = (r_state == IDLE);
    assign dbg_state     = r_state;
    assign voice_active  = r_active;
    assign voice_restart = r_restart;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign voice_note[7*g +: 7]   = r_note[g];
        assign voice_volume[7*g +: 7] = r_vol[g];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_scan_idx    <= '0;
            r_ev_sound    <= 1'b0;
            r_ev_note     <= '0;
            r_ev_vel      <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_oldest_idx  <= '0;
        end else if (all_off) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state       <= SCAN;
                        r_scan_idx    <= '0;
                        r_ev_sound    <= ev_on && (ev_velocity != 7'd0);
                        r_ev_note     <= ev_note;
                        r_ev_vel      <= ev_velocity;
                        r_match_found <= 1'b0;
                        r_free_found  <= 1'b0;
                    end
                end
                SCAN: begin
                    if (!r_match_found && r_active[r_scan_idx] &&
                        (r_note[r_scan_idx] == r_ev_note)) begin
                        r_match_found <= 1'b1;
                        r_match_idx   <= r_scan_idx;
                    end
                    if (!r_free_found && !r_active[r_scan_idx]) begin
                        r_free_found <= 1'b1;
                        r_free_idx   <= r_scan_idx;
                    end
                    if (r_rank[r_scan_idx] == LAST_IDX) begin
                        r_oldest_idx <= r_scan_idx;
                    end
                    if (r_scan_idx == LAST_IDX) begin
                        r_state <= APPLY;
                    end else begin
                        r_scan_idx <= r_scan_idx + IDX_W'(1);
                    end
                end
                APPLY:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_active  <= '0;
            r_restart <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_note[i] <= '0;
                r_vol[i]  <= '0;
            end
        end else begin
            r_restart <= '0;
            if (all_off) begin
                r_active <= '0;
                for (int i = 0; i < NUM_VOICES; i++) begin
                    r_vol[i] <= '0;
                end
            end else if (w_apply_on) begin
                r_note[w_target]    <= r_ev_note;
                r_vol[w_target]     <= r_ev_vel;
                r_active[w_target]  <= 1'b1;
                r_restart[w_target] <= 1'b1;
            end else if (w_apply_off) begin
                r_vol[r_match_idx]    <= '0;
                r_active[r_match_idx] <= 1'b0;
            end
        end
    end

    // Rank 0 is the most recently assigned voice; moving the target to the front keeps a permutation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_rank[i] <= IDX_W'(i);
            end
        end else if (w_apply_on) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == w_target) begin
                    r_rank[i] <= '0;
                end else if (r_rank[i] < r_rank[w_target]) begin
                    r_rank[i] <= r_rank[i] + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphony controller in front of a bank of NUM_VOICES square-wave tone generators.
- Accepts MIDI note-on/note-off events over a valid/ready handshake and assigns each note to a voice. Voice selection order: retrigger of the same note, then a free voice, then theft of the least-recently-assigned voice.
- Per voice, drives the note number, the volume, an active flag and a one-cycle restart pulse. The restart pulse feeds the generator's synchronous reset.
- The note-to-period lookup sits downstream and is outside this block.

Parameters:
- NUM_VOICES, 4, number of generator voices managed; must be 2..16.
- IDX_W, 2, voice index width; equals clog2(NUM_VOICES).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ev_valid  in  1  event present.
- ev_ready  out  1  block can accept an event.
- ev_on  in  1  1 = note-on, 0 = note-off.
- ev_note  in  7  MIDI note number.
- ev_velocity  in  7  MIDI velocity; note-on with velocity 0 is treated as note-off.
- all_off  in  1  single-cycle pulse that silences all voices.
- voice_note  out  7*NUM_VOICES  note per voice; voice i occupies bits [7i+6:7i].
- voice_volume  out  7*NUM_VOICES  volume per voice; 0 when the voice is inactive.
- voice_active  out  NUM_VOICES  voice is sounding.
- voice_restart  out  NUM_VOICES  one-cycle pulse when a voice is (re)assigned.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, ev_ready=1.
  - All voice_note=0, voice_volume=0, voice_active=0, voice_restart=0.
  - Age rank of voice i = i, so voice NUM_VOICES-1 is the oldest.
  - Reset asserted mid-scan aborts the event; the event is not replayed.
- Handshake:
  - An event is accepted on the rising edge where ev_valid && ev_ready.
  - The event fields are latched at that edge; the inputs may then change freely.
  - ev_ready is 1 only in IDLE.
- FSM states: IDLE, SCAN, APPLY.
  - IDLE -> SCAN on accept.
  - SCAN examines one voice per cycle, index 0 upward, for NUM_VOICES cycles.
  - SCAN -> APPLY after index NUM_VOICES-1.
  - APPLY -> IDLE after one cycle.
  - Result: ev_ready is low for exactly NUM_VOICES+1 cycles after an accept.
- SCAN bookkeeping, per scanned voice:
  - Record the first active voice whose note matches (match).
  - Record the first inactive voice (free).
  - Record the voice holding rank NUM_VOICES-1 (oldest).
- APPLY, note-on with velocity > 0:
  - Target voice = match if found, else free if found, else oldest.
  - Target: note=ev_note, volume=ev_velocity, active=1.
  - Target voice_restart pulses high for the one cycle after APPLY, aligned with the output update.
  - Ranks: target rank becomes 0; every voice whose rank was below the target's old rank increments by 1. Ranks always remain a permutation of 0..NUM_VOICES-1.
- APPLY, note-off (or note-on with velocity 0):
  - If match is found, clear that voice: active=0, volume=0. voice_note holds its last value. No restart pulse, no rank change.
  - If no match is found, no output changes.
- Output timing: voice outputs are registered and change on the edge that leaves APPLY, the same edge where ev_ready returns to 1.
- all_off:
  - Takes effect at the next edge in any state: all voices active=0, volume=0.
  - If an event is in flight, it is discarded and the FSM returns to IDLE; ranks are unchanged.
  - all_off has priority over an APPLY in the same cycle.
- Edge cases:
  - A duplicate note-on for an already-sounding note retriggers that voice; it does not allocate a second voice.
  - voice_restart is 0 in every cycle except the single post-APPLY cycle of a note-on.

Test Plan (NUM_VOICES=4):
- Reset release -> ev_ready=1, voice_active=0000, all volumes 0. Note-on 60 vel 100 -> ev_ready low 5 cycles; then voice0 note=60 vol=100, active=0001, restart=0001 for exactly 1 cycle.
- Note-ons 60, 62, 64, 65 then 67 (each vel 80) -> voices 0..3 fill in order; 67 steals voice0 (oldest), restart=0001, voice0 note=67.
- Note-off 62 -> voice1 active=0, vol=0, no restart pulse; a following note-on 69 lands on voice1.
- Note-on 64 while 64 is already held on voice2 with vel 50 -> voice2 vol=50, restart=0100, active count unchanged. Note-on 64 vel 0 -> voice2 cleared.
- Note-off 70 with no voice holding 70 -> outputs unchanged, ev_ready returns after 5 cycles.
- all_off pulsed during SCAN -> next edge: active=0000, FSM in IDLE, ev_ready=1. Reset asserted mid-SCAN -> all outputs cleared immediately without a clock edge.
